fc_layer_v2: RTL and testbench

FC_LAYER_V2 -- requirements
Module: fc_layer_v2

---
 rtl/fc_layer_v2.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_fc_layer_v2.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_v2.sv
// fc_layer_v2: fully-connected layer on a streamed input vector.
//
// A C_IN-sample input blob is buffered, then C_OUT output neurons are
// computed KPF at a time. For each group, C_IN weight beats stream in (one
// weight per lane per beat). A 2-stage pipeline (buffer read / weight
// register, then multiply-accumulate) builds one accumulator per lane. After
// the group's last beat the results are shifted, optionally ReLU'd,
// saturated, and drained one lane per handshake.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   blob_din_*     input sample stream (en/data/eop) with blob_din_rdy
//   wt_din_en      weight beat valid, wt_din = KPF lanes of WW bits
//   bias_din       KPF lanes of BIAS_DW bits, taken with a group's first beat
//   wt_din_rdy     weight beat accepted (MAC state only)
//   blob_dout_*    output sample stream (en/data/eop) with blob_dout_rdy
//   busy           controller not idle
//   err            sticky input framing error (misplaced or missing eop)
module fc_layer_v2 #(
  parameter int C_IN    = 1024,
  parameter int C_OUT   = 64,
  parameter int KPF     = 4,
  parameter int DIN_DW  = 16,
  parameter int WW      = 4,
  parameter int BIAS_DW = 8,
  parameter int ACC_W   = 40,
  parameter int Q       = 4,
  parameter int RELU    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   blob_din_en,
  input  logic [DIN_DW-1:0]      blob_din,
  input  logic                   blob_din_eop,
  output logic                   blob_din_rdy,
  input  logic                   wt_din_en,
  input  logic [KPF*WW-1:0]      wt_din,
  input  logic [KPF*BIAS_DW-1:0] bias_din,
  output logic                   wt_din_rdy,
  output logic                   blob_dout_en,
  output logic [DIN_DW-1:0]      blob_dout,
  output logic                   blob_dout_eop,
  input  logic                   blob_dout_rdy,
  output logic                   busy,
  output logic                   err
);

  localparam int N_GRP = C_OUT / KPF;
  localparam int IW    = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam int LW    = (KPF > 1) ? $clog2(KPF) : 1;
  localparam int PW    = DIN_DW + WW;

  localparam logic [IW-1:0] IN_LAST   = IW'(C_IN - 1);
  localparam logic [GW-1:0] GRP_LAST  = GW'(N_GRP - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(KPF - 1);
  localparam logic          ONE_LANE  = (KPF == 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DIN_DW+1){1'b0}}, {(DIN_DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DIN_DW+1){1'b1}}, {(DIN_DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Bias aligned to the accumulator's fixed-point scale.
  function automatic logic signed [ACC_W-1:0] bias_init(input logic [BIAS_DW-1:0] b);
    logic signed [ACC_W-1:0] ext;
    ext = {{(ACC_W-BIAS_DW){b[BIAS_DW-1]}}, b};
    return ext <<< Q;
  endfunction

  // Scale down (floor), optional ReLU, then clip to the output sample range.
  function automatic logic [DIN_DW-1:0] fc_result(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] val;
    val = acc >>> Q;
    if ((RELU != 0) && val[ACC_W-1]) begin
      val = {ACC_W{1'b0}};
    end else begin
      val = val;
    end
    if (val > SAT_MAX) begin
      val = SAT_MAX;
    end else if (val < SAT_MIN) begin
      val = SAT_MIN;
    end else begin
      val = val;
    end
    return val[DIN_DW-1:0];
  endfunction

  state_t                   state_r, state_nxt_s;
  logic [DIN_DW-1:0]        buf_r [C_IN];
  logic [IW-1:0]            in_cnt_r;
  logic [IW-1:0]            beat_cnt_r;
  logic [GW-1:0]            grp_cnt_r;
  logic [LW-1:0]            lane_r;
  logic                     flush_cnt_r;
  logic                     err_r;
  logic                     din_rdy_r, wt_rdy_r, busy_r;
  logic [DIN_DW-1:0]        din_s1_r;
  logic [KPF*WW-1:0]        w_s1_r;
  logic [KPF*BIAS_DW-1:0]   bias_s1_r;
  logic                     vld_s1_r, first_s1_r;
  logic signed [ACC_W-1:0]  acc_r [KPF];
  logic [DIN_DW-1:0]        dout_r;
  logic                     dout_en_r, dout_eop_r;

  logic                     din_acc_s, wt_acc_s, out_xfer_s;
  logic                     in_last_s, beat_last_s, grp_last_s, lane_last_s;
  logic [LW-1:0]            lane_nxt_s;
  logic [WW-1:0]            w_lane_s [KPF];
  logic signed [PW-1:0]     prod_s [KPF];

  assign din_acc_s   = blob_din_en && din_rdy_r && ((state_r == S_IDLE) || (state_r == S_LOAD));
  assign wt_acc_s    = wt_din_en && wt_rdy_r && (state_r == S_MAC);
  assign out_xfer_s  = dout_en_r && blob_dout_rdy;
  assign in_last_s   = (in_cnt_r == IN_LAST);
  assign beat_last_s = (beat_cnt_r == IN_LAST);
  assign grp_last_s  = (grp_cnt_r == GRP_LAST);
  assign lane_last_s = (lane_r == LANE_LAST);
  assign lane_nxt_s  = lane_r + LW'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE, S_LOAD: begin
        if (din_acc_s && in_last_s) begin
          state_nxt_s = S_MAC;
        end else if (din_acc_s) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_MAC: begin
        if (wt_acc_s && beat_last_s) begin
          state_nxt_s = S_FLUSH;
        end else begin
          state_nxt_s = S_MAC;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_r) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_FLUSH;
        end
      end
      S_DRAIN: begin
        if (out_xfer_s && lane_last_s) begin
          state_nxt_s = grp_last_s ? S_IDLE : S_MAC;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake and status flags, registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_rdy_r <= 1'b0;
      wt_rdy_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      din_rdy_r <= (state_nxt_s == S_IDLE) || (state_nxt_s == S_LOAD);
      wt_rdy_r  <= (state_nxt_s == S_MAC);
      busy_r    <= (state_nxt_s != S_IDLE);
    end
  end

  // Beat/group counters, flush timer and sticky framing error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_r    <= {IW{1'b0}};
      beat_cnt_r  <= {IW{1'b0}};
      grp_cnt_r   <= {GW{1'b0}};
      flush_cnt_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (din_acc_s) begin
        in_cnt_r <= in_last_s ? {IW{1'b0}} : in_cnt_r + IW'(1);
        // eop must appear on exactly the last beat; loading still goes by count
        if (blob_din_eop != in_last_s) begin
          err_r <= 1'b1;
        end
      end
      if (wt_acc_s) begin
        beat_cnt_r <= beat_last_s ? {IW{1'b0}} : beat_cnt_r + IW'(1);
      end
      flush_cnt_r <= (state_r == S_FLUSH) ? ~flush_cnt_r : 1'b0;
      if ((state_r == S_DRAIN) && out_xfer_s && lane_last_s) begin
        grp_cnt_r <= grp_last_s ? {GW{1'b0}} : grp_cnt_r + GW'(1);
      end
    end
  end

  // Input vector buffer, written by beat count
  always_ff @(posedge clk) begin
    if (din_acc_s) begin
      buf_r[in_cnt_r] <= blob_din;
    end
  end

  // Stage 1: buffer read and weight/bias register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_s1_r   <= {DIN_DW{1'b0}};
      w_s1_r     <= {(KPF*WW){1'b0}};
      bias_s1_r  <= {(KPF*BIAS_DW){1'b0}};
      vld_s1_r   <= 1'b0;
      first_s1_r <= 1'b0;
    end else begin
      vld_s1_r   <= wt_acc_s;
      first_s1_r <= wt_acc_s && (beat_cnt_r == {IW{1'b0}});
      if (wt_acc_s) begin
        din_s1_r <= buf_r[beat_cnt_r];
        w_s1_r   <= wt_din;
      end
      if (wt_acc_s && (beat_cnt_r == {IW{1'b0}})) begin
        bias_s1_r <= bias_din;
      end
    end
  end

  // Per-lane full-precision signed products of the stage-1 operands
  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      w_lane_s[k] = w_s1_r[k*WW +: WW];
      prod_s[k]   = $signed({{WW{din_s1_r[DIN_DW-1]}}, din_s1_r}) *
                    $signed({{DIN_DW{w_lane_s[k][WW-1]}}, w_lane_s[k]});
    end
  end

  // Stage 2: accumulate; the group's first beat restarts from the bias
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < KPF; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else if (vld_s1_r) begin
      for (int k = 0; k < KPF; k++) begin
        acc_r[k] <= (first_s1_r ? bias_init(bias_s1_r[k*BIAS_DW +: BIAS_DW]) : acc_r[k]) +
                    {{(ACC_W-PW){prod_s[k][PW-1]}}, prod_s[k]};
      end
    end
  end

  // Output register: loads lane 0 at the end of FLUSH, advances on each transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_r     <= {DIN_DW{1'b0}};
      dout_en_r  <= 1'b0;
      dout_eop_r <= 1'b0;
      lane_r     <= {LW{1'b0}};
    end else if ((state_r == S_FLUSH) && flush_cnt_r) begin
      dout_r     <= fc_result(acc_r[0]);
      dout_en_r  <= 1'b1;
      dout_eop_r <= ONE_LANE && grp_last_s;
      lane_r     <= {LW{1'b0}};
    end else if (out_xfer_s) begin
      if (lane_last_s) begin
        dout_en_r  <= 1'b0;
        dout_eop_r <= 1'b0;
      end else begin
        dout_r     <= fc_result(acc_r[lane_nxt_s]);
        dout_eop_r <= (lane_nxt_s == LANE_LAST) && grp_last_s;
        lane_r     <= lane_nxt_s;
      end
    end
  end

  assign blob_din_rdy  = din_rdy_r;
  assign wt_din_rdy    = wt_rdy_r;
  assign blob_dout_en  = dout_en_r;
  assign blob_dout     = dout_r;
  assign blob_dout_eop = dout_eop_r;
  assign busy          = busy_r;
  assign err           = err_r;

endmodule

// File: tb/tb_fc_layer_v2.sv
// Bench for fc_layer_v2: three instances share all inputs and differ only in
// Q/RELU (0/0, 0/1, 4/0). Outputs are compared with a plain-arithmetic
// reference model of the layer.
module tb_fc_layer_v2;

  localparam int CI = 4;
  localparam int CO = 4;
  localparam int KP = 2;
  localparam int NG = CO / KP;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int BW = 8;

  logic               clk, rst;
  logic               blob_din_en, blob_din_eop, wt_din_en, blob_dout_rdy;
  logic [DW-1:0]      blob_din;
  logic [KP*W-1:0]    wt_din;
  logic [KP*BW-1:0]   bias_din;
  logic [2:0]         din_rdy_v, wt_rdy_v, dout_en_v, eop_v, busy_v, err_v;
  logic [2:0][DW-1:0] dout_v;

  longint vec [CI];
  longint wts [NG][KP][CI];
  longint bs  [NG][KP];
  longint exp_out [NG][KP][3];
  logic   exp_err;
  int     n_checks, n_errors;

  fc_layer_v2 #(.C_IN(CI), .C_OUT(CO), .KPF(KP), .DIN_DW(DW), .WW(W), .BIAS_DW(BW),
                .ACC_W(40), .Q(0), .RELU(0)) u_q0 (
    .clk(clk), .rst(rst), .blob_din_en(blob_din_en), .blob_din(blob_din),
    .blob_din_eop(blob_din_eop), .blob_din_rdy(din_rdy_v[0]), .wt_din_en(wt_din_en),
    .wt_din(wt_din), .bias_din(bias_din), .wt_din_rdy(wt_rdy_v[0]),
    .blob_dout_en(dout_en_v[0]), .blob_dout(dout_v[0]), .blob_dout_eop(eop_v[0]),
    .blob_dout_rdy(blob_dout_rdy), .busy(busy_v[0]), .err(err_v[0]));

  fc_layer_v2 #(.C_IN(CI), .C_OUT(CO), .KPF(KP), .DIN_DW(DW), .WW(W), .BIAS_DW(BW),
                .ACC_W(40), .Q(0), .RELU(1)) u_relu (
    .clk(clk), .rst(rst), .blob_din_en(blob_din_en), .blob_din(blob_din),
    .blob_din_eop(blob_din_eop), .blob_din_rdy(din_rdy_v[1]), .wt_din_en(wt_din_en),
    .wt_din(wt_din), .bias_din(bias_din), .wt_din_rdy(wt_rdy_v[1]),
    .blob_dout_en(dout_en_v[1]), .blob_dout(dout_v[1]), .blob_dout_eop(eop_v[1]),
    .blob_dout_rdy(blob_dout_rdy), .busy(busy_v[1]), .err(err_v[1]));

  fc_layer_v2 #(.C_IN(CI), .C_OUT(CO), .KPF(KP), .DIN_DW(DW), .WW(W), .BIAS_DW(BW),
                .ACC_W(40), .Q(4), .RELU(0)) u_q4 (
    .clk(clk), .rst(rst), .blob_din_en(blob_din_en), .blob_din(blob_din),
    .blob_din_eop(blob_din_eop), .blob_din_rdy(din_rdy_v[2]), .wt_din_en(wt_din_en),
    .wt_din(wt_din), .bias_din(bias_din), .wt_din_rdy(wt_rdy_v[2]),
    .blob_dout_en(dout_en_v[2]), .blob_dout(dout_v[2]), .blob_dout_eop(eop_v[2]),
    .blob_dout_rdy(blob_dout_rdy), .busy(busy_v[2]), .err(err_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: out = sat(relu(floor((bias*2^q + sum din*w) / 2^q)))
  function automatic longint model(input int g, input int k, input int d);
    longint acc, r;
    int q;
    q = (d == 2) ? 4 : 0;
    acc = bs[g][k] * (longint'(1) << q);
    for (int i = 0; i < CI; i++) acc += vec[i] * wts[g][k][i];
    r = acc >>> q;
    if (d == 1 && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic set_group(input int g, input longint w0, input longint w1,
                           input longint b0, input longint b1);
    for (int i = 0; i < CI; i++) begin
      wts[g][0][i] = w0;
      wts[g][1][i] = w1;
    end
    bs[g][0] = b0;
    bs[g][1] = b1;
  endtask

  task automatic randomize_all();
    logic [DW-1:0] t16;
    logic [7:0]    t8;
    for (int i = 0; i < CI; i++) begin
      t16 = DW'($urandom);
      vec[i] = $signed(t16);
    end
    for (int g = 0; g < NG; g++)
      for (int k = 0; k < KP; k++) begin
        t8 = 8'($urandom);
        bs[g][k] = $signed(t8);
        for (int i = 0; i < CI; i++) begin
          t8 = 8'($urandom);
          wts[g][k][i] = $signed(t8);
        end
      end
  endtask

  task automatic send_vec(input int eop_pos);
    int i, guard;
    i = 0; guard = 0;
    while (i < CI && guard < 100) begin
      @(negedge clk); guard++;
      blob_din_en  = 1'b1;
      blob_din     = vec[i][DW-1:0];
      blob_din_eop = (i == eop_pos);
      wt_din_en    = 1'($urandom_range(0, 1));
      wt_din       = (KP*W)'($urandom);
      if (din_rdy_v[0]) i++;
    end
    check("vec_beats", i, CI);
    @(negedge clk);
    blob_din_en = 1'b0; blob_din_eop = 1'b0; wt_din_en = 1'b0;
  endtask

  task automatic send_weights(input int g, input int stall, input int nb);
    int i, guard, lat;
    logic en;
    i = 0; guard = 0;
    blob_dout_rdy = 1'b0;
    check("din_rdy_in_mac", din_rdy_v[0], 0);
    while (i < nb && guard < 200) begin
      @(negedge clk); guard++;
      en = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      wt_din_en = en;
      for (int k = 0; k < KP; k++) begin
        wt_din[k*W +: W]    = en ? wts[g][k][i][W-1:0] : W'($urandom);
        bias_din[k*BW +: BW] = (en && i == 0) ? bs[g][k][BW-1:0] : BW'($urandom);
      end
      blob_din_en = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      blob_din    = DW'($urandom);
      if (en && wt_rdy_v[0]) i++;
    end
    check("wt_beats", i, nb);
    @(negedge clk);
    wt_din_en = 1'b0; blob_din_en = 1'b0;
    if (nb == CI) begin
      check("wt_rdy_flush", wt_rdy_v[0], 0);
      lat = 1;
      while (!dout_en_v[0] && lat < 10) begin
        @(negedge clk); lat++;
      end
      check("dout_latency", lat, 3);
    end
  endtask

  task automatic collect(input int g, input int hold);
    int lane, guard, held;
    logic pend;
    logic [2:0][DW-1:0] pd;
    logic [2:0] pe;
    lane = 0; guard = 0; held = 0;
    pend = dout_en_v[0]; pd = dout_v; pe = eop_v;
    while (lane < KP && guard < 200) begin
      @(negedge clk); guard++;
      if (pend) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("hold_en%0d", d), dout_en_v[d], 1);
          check($sformatf("hold_dout%0d", d), dout_v[d], pd[d]);
          check($sformatf("hold_eop%0d", d), eop_v[d], pe[d]);
        end
      end
      pend = 1'b0;
      if (dout_en_v[0]) begin
        if (held < hold) begin
          blob_dout_rdy = 1'b0; held++;
        end else begin
          blob_dout_rdy = (hold > 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (blob_dout_rdy) begin
          for (int d = 0; d < 3; d++) begin
            check($sformatf("dout%0d_g%0d_k%0d", d, g, lane), $signed(dout_v[d]),
                  exp_out[g][lane][d]);
            check($sformatf("eop%0d_g%0d_k%0d", d, g, lane), eop_v[d],
                  (g == NG-1 && lane == KP-1) ? 1 : 0);
          end
          lane++;
        end else begin
          pend = 1'b1; pd = dout_v; pe = eop_v;
        end
      end else begin
        blob_dout_rdy = 1'($urandom_range(0, 1));
      end
    end
    check("out_count", lane, KP);
    @(negedge clk);
    blob_dout_rdy = 1'b0;
    for (int d = 0; d < 3; d++) check($sformatf("no_extra_out%0d", d), dout_en_v[d], 0);
    check("wt_rdy_after_drain", wt_rdy_v[0], (g < NG-1) ? 1 : 0);
    check("busy_after_drain", busy_v[0], (g < NG-1) ? 1 : 0);
  endtask

  task automatic run_layer(input int eop_pos, input int stall, input int hold);
    for (int g = 0; g < NG; g++)
      for (int k = 0; k < KP; k++)
        for (int d = 0; d < 3; d++) exp_out[g][k][d] = model(g, k, d);
    send_vec(eop_pos);
    if (eop_pos != CI-1) exp_err = 1'b1;
    for (int g = 0; g < NG; g++) begin
      send_weights(g, stall, CI);
      collect(g, hold);
    end
    for (int d = 0; d < 3; d++) check($sformatf("err%0d", d), err_v[d], exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_din_rdy%0d", tag, d), din_rdy_v[d], 0);
      check($sformatf("%s_wt_rdy%0d", tag, d), wt_rdy_v[d], 0);
      check($sformatf("%s_dout_en%0d", tag, d), dout_en_v[d], 0);
      check($sformatf("%s_dout%0d", tag, d), dout_v[d], 0);
      check($sformatf("%s_eop%0d", tag, d), eop_v[d], 0);
      check($sformatf("%s_busy%0d", tag, d), busy_v[d], 0);
      check($sformatf("%s_err%0d", tag, d), err_v[d], 0);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_err = 1'b0;
    rst = 1'b1;
    blob_din_en = 1'b0; blob_din = '0; blob_din_eop = 1'b0;
    wt_din_en = 1'b0; wt_din = '0; bias_din = '0; blob_dout_rdy = 1'b0;

    // Power-on reset
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);
    check("din_rdy_after_rst", din_rdy_v[0], 1);
    check("busy_after_rst", busy_v[0], 0);

    // Basic dot products: din 1..4, lane0 w=1, lane1 w=-1, bias 0
    for (int i = 0; i < CI; i++) vec[i] = i + 1;
    set_group(0, 1, -1, 0, 0);
    set_group(1, 2, -3, 0, 0);
    run_layer(CI-1, 0, 0);

    // ReLU bias lane1=3; Q=4 lane0 w=16 bias 1
    set_group(0, 16, -1, 1, 3);
    set_group(1, -5, 7, -2, 4);
    run_layer(CI-1, 0, 0);

    // Positive and negative saturation
    for (int i = 0; i < CI; i++) vec[i] = 32767;
    set_group(0, 7, -7, 0, 0);
    set_group(1, 7, 1, 0, 0);
    run_layer(CI-1, 0, 0);
    for (int i = 0; i < CI; i++) vec[i] = -32768;
    run_layer(CI-1, 0, 0);

    // Framing error: eop on beat 2; results still from all 4 beats
    for (int i = 0; i < CI; i++) vec[i] = 3 * i - 5;
    set_group(0, 3, -2, 5, -6);
    set_group(1, -8, 9, 0, 1);
    run_layer(2, 0, 0);

    // Random data, stalled weights, held back-pressure; err must stay set
    for (int r = 0; r < 4; r++) begin
      randomize_all();
      run_layer(CI-1, 1, 5);
    end

    // Reset in the middle of MAC
    randomize_all();
    send_vec(CI-1);
    send_weights(0, 0, 2);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_mac");
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("din_rdy_after_mid_rst", din_rdy_v[0], 1);

    // Full random vector after reset
    for (int r = 0; r < 2; r++) begin
      randomize_all();
      run_layer(CI-1, 1, 5);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
